// File: rtl/bl_wl_loader_pkg.sv
// Purpose: shared types and helpers for the BL/WL configuration-frame loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: loader state enum, counter-width helper.
package bl_wl_loader_pkg;

  // Loader sequencing states. The ST_ prefix keeps ST_DONE distinct from the
  // DONE output port of the top level.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_LOAD_BL  = 3'd2,
    ST_SHIFT_WL = 3'd3,
    ST_PROG     = 3'd4,
    ST_CLEAR    = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Width of a counter that must be able to hold the value n without wrapping.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int BL_LEN_MIN = 2;
  localparam int BL_LEN_MAX = 64;

endpackage

// File: rtl/bl_wl_loader_piso.sv
// Purpose: parallel-load, MSB-first shift register feeding the BL chain head.
// Latency: SOUT shows PDIN[WIDTH-1] the cycle after LOAD; one bit per SHIFT cycle after that.
// Backpressure: none; LOAD wins over SHIFT, zeros fill from the LSB end.
// Ports: CK/RSTN clock and sync active-low reset, LOAD/SHIFT enables,
//        PDIN parallel word, SOUT serial output (register MSB, so registered).
module bl_wl_loader_piso #(
  parameter int WIDTH = 16
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             LOAD,
  input  logic             SHIFT,
  input  logic [WIDTH-1:0] PDIN,
  output logic             SOUT
);

  logic [WIDTH-1:0] sr;

  // Shifting zeros in means the register is empty again after WIDTH shifts,
  // so SOUT idles at 0 between frames without extra gating.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      sr <= '0;
    end else if (LOAD) begin
      sr <= PDIN;
    end else if (SHIFT) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign SOUT = sr[WIDTH-1];

endmodule

// File: rtl/bl_wl_shift_loader.sv
// Purpose: loads WL_LEN frames into BL/WL shift chains: serialise BL word, step WL token, strobe PROG_EN.
// Latency: BL_SHIFT 1 cycle after handshake; frame period BL_LEN+PROG_CYCLES+2 cycles best case.
// Backpressure: DIN_READY only in WAIT; source stalls by holding DIN_VALID low, loader waits indefinitely.
// Ports: CK clock, RSTN sync active-low reset, START load request (IDLE/DONE only),
//        DIN/DIN_VALID/DIN_READY frame handshake, BL_SIN/BL_SHIFT and WL_SIN/WL_SHIFT chain
//        drives, PROG_EN programming strobe, DONE completion flag.
// Option: define BL_WL_LOADER_PARITY_EN to add DIN_PARITY (even parity over DIN, sampled at
//         handshake) and sticky PARITY_ERR (cleared by an accepted START or reset).
module bl_wl_shift_loader
  import bl_wl_loader_pkg::*;
#(
  parameter int BL_LEN      = 16,
  parameter int WL_LEN      = 8,
  parameter int PROG_CYCLES = 2
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              START,
  input  logic [BL_LEN-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              BL_SIN,
  output logic              BL_SHIFT,
  output logic              WL_SIN,
  output logic              WL_SHIFT,
  output logic              PROG_EN,
  output logic              DONE
`ifdef BL_WL_LOADER_PARITY_EN
  ,
  input  logic              DIN_PARITY,
  output logic              PARITY_ERR
`endif
);

  localparam int BW = cnt_w(BL_LEN);
  localparam int FW = cnt_w(WL_LEN);
  localparam int HW = cnt_w(PROG_CYCLES);

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [FW-1:0] frame_cnt;
  logic [HW-1:0] hold_cnt;

  logic hs;          // frame accepted this cycle
  logic piso_shift;
  logic start_ok;    // START is honoured only when idle or finished

  assign hs         = (state == ST_WAIT) && DIN_VALID;
  assign piso_shift = (state == ST_LOAD_BL);
  assign start_ok   = START && ((state == ST_IDLE) || (state == ST_DONE));

  bl_wl_loader_piso #(
    .WIDTH (BL_LEN)
  ) u_piso (
    .CK    (CK),
    .RSTN  (RSTN),
    .LOAD  (hs),
    .SHIFT (piso_shift),
    .PDIN  (DIN),
    .SOUT  (BL_SIN)
  );

  // All outputs are set one cycle ahead of the state they belong to, so each
  // is a plain flop that is already valid on entry to that state.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      hold_cnt  <= '0;
      DIN_READY <= 1'b0;
      BL_SHIFT  <= 1'b0;
      WL_SIN    <= 1'b0;
      WL_SHIFT  <= 1'b0;
      PROG_EN   <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            frame_cnt <= '0;
            DIN_READY <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (DIN_VALID) begin
            DIN_READY <= 1'b0;
            BL_SHIFT  <= 1'b1;
            bit_cnt   <= '0;
            state     <= ST_LOAD_BL;
          end
        end

        ST_LOAD_BL: begin
          if (bit_cnt == BW'(BL_LEN - 1)) begin
            BL_SHIFT <= 1'b0;
            WL_SHIFT <= 1'b1;
            // Only the first frame injects the token; later frames push it along.
            WL_SIN   <= (frame_cnt == '0);
            state    <= ST_SHIFT_WL;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end

        ST_SHIFT_WL: begin
          WL_SHIFT <= 1'b0;
          WL_SIN   <= 1'b0;
          PROG_EN  <= 1'b1;
          hold_cnt <= '0;
          state    <= ST_PROG;
        end

        ST_PROG: begin
          if (hold_cnt == HW'(PROG_CYCLES - 1)) begin
            PROG_EN   <= 1'b0;
            frame_cnt <= frame_cnt + FW'(1);
            if (frame_cnt == FW'(WL_LEN - 1)) begin
              // Last frame: one more WL shift with a 0 pushes the token out.
              WL_SHIFT <= 1'b1;
              WL_SIN   <= 1'b0;
              state    <= ST_CLEAR;
            end else begin
              DIN_READY <= 1'b1;
              state     <= ST_WAIT;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        ST_CLEAR: begin
          WL_SHIFT <= 1'b0;
          DONE     <= 1'b1;
          state    <= ST_DONE;
        end

        ST_DONE: begin
          if (START) begin
            DONE      <= 1'b0;
            frame_cnt <= '0;
            DIN_READY <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BL_WL_LOADER_PARITY_EN
  // Sticky error; the frame is still loaded even when parity is wrong.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      PARITY_ERR <= 1'b0;
    end else if (start_ok) begin
      PARITY_ERR <= 1'b0;
    end else if (hs && ((^DIN) != DIN_PARITY)) begin
      PARITY_ERR <= 1'b1;
    end
  end
`else
  // start_ok only feeds the parity flag; keep it referenced in the lean build.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: doc/bl_wl_shift_loader.md
# bl_wl_shift_loader

Configuration-frame loader that sits directly upstream of the BL/WL shift-register chains built from `BL_DFFRQ` / `WL_DFFRQ` cells. For each frame it serialises one bit-line word into the BL chain, advances a one-hot token through the WL chain, then holds a programming strobe for a fixed number of cycles. It repeats this once per word line, then clears the WL token and reports completion. Frames arrive over a valid/ready handshake from the bitstream source.

## Interface
- `BL_LEN`, 16: BL chain length and frame word width; must be ≥2 and ≤64.
- `WL_LEN`, 8: WL chain length, which is also the number of frames per load; must be ≥1.
- `PROG_CYCLES`, 2: cycles `PROG_EN` is held per frame; must be ≥1.

Ports:
- `CK` input 1: clock. Everything is on the rising edge.
- `RSTN` input 1: **synchronous, active-low reset**.
- `START` input 1: single-cycle pulse that begins a load. Honoured only in IDLE or DONE.
- `DIN` input BL_LEN: frame word. `DIN[k]` ends up in BL chain element k.
- `DIN_VALID` input 1: frame word valid.
- `DIN_READY` output 1: loader can accept a frame.
- `BL_SIN` output 1: serial data to the BL chain head (`SIN`).
- `BL_SHIFT` output 1: shift enable for the BL chain; gates the chain clock externally.
- `WL_SIN` output 1: serial data to the WL chain head.
- `WL_SHIFT` output 1: shift enable for the WL chain.
- `PROG_EN` output 1: programming strobe.
- `DONE` output 1: all WL_LEN frames are written.

## Operation
- All outputs are registered. Every output resets to 0, the state resets to IDLE and all counters reset to 0.
- **IDLE**: all outputs 0. On `START`, clear the frame counter and go to WAIT.
- **WAIT**: `DIN_READY`=1.
  - On `DIN_VALID`&&`DIN_READY`, latch `DIN` into the serialiser and go to LOAD_BL.
  - `DIN_READY` is 0 in every other state.
- **LOAD_BL**: runs for exactly BL_LEN cycles with `BL_SHIFT`=1.
  - `BL_SIN` presents `DIN[BL_LEN-1]` first and `DIN[0]` last.
  - Then go to SHIFT_WL.
- **SHIFT_WL**: one cycle with `WL_SHIFT`=1. `WL_SIN`=1 when the frame counter is 0, otherwise 0. After frame f the token sits at WL element f. Then go to PROG.
- **PROG**: `PROG_EN`=1 for PROG_CYCLES cycles. Then increment the frame counter.
  - If the counter equals WL_LEN, go to CLEAR.
  - Otherwise go to WAIT.
- **CLEAR**: one cycle with `WL_SHIFT`=1 and `WL_SIN`=0, which pushes the token off the chain end. Then go to DONE.
- **DONE**: `DONE`=1, all other outputs 0. `START` clears `DONE` and restarts from frame 0 (goes to WAIT).
- `START` is ignored in WAIT, LOAD_BL, SHIFT_WL, PROG and CLEAR.
- `DIN_VALID` is ignored while `DIN_READY`=0. The source must hold `DIN` stable only until the handshake cycle.
- `BL_SHIFT`, `WL_SHIFT` and `PROG_EN` are never high in the same cycle.
- Counter widths: the bit counter is $clog2(BL_LEN+1), the frame counter $clog2(WL_LEN+1), the hold counter $clog2(PROG_CYCLES+1). No counter wraps.

## Timing
- Handshake at edge E. `BL_SHIFT` is high in cycles E+1 … E+BL_LEN.
- `WL_SHIFT` is high at E+BL_LEN+1.
- `PROG_EN` is high at E+BL_LEN+2 … E+BL_LEN+1+PROG_CYCLES.
- `DIN_READY` rises in the following cycle, giving a best-case frame period of BL_LEN+PROG_CYCLES+2.
- `START` at edge S gives `DIN_READY`=1 in cycle S+1.
- `DONE` rises two cycles after the last `PROG_EN` cycle: one CLEAR cycle, then DONE.
- Reset mid-operation: on the first edge with `RSTN`=0 all outputs go to 0 and the state returns to IDLE. Partially shifted chain contents are left untouched; the chains have their own reset.

## Configuration
- `BL_WL_LOADER_PARITY_EN` defined:
  - Adds input `DIN_PARITY` (1 bit, even parity over `DIN`, sampled at the handshake) and output `PARITY_ERR` (1 bit).
  - A mismatch sets `PARITY_ERR`. It is sticky until `START` or reset and resets to 0.
  - The frame is still loaded.
- Undefined: neither port exists and no parity logic is generated.

## Structure
- Package `bl_wl_loader_pkg` holds:
  - the state enum (IDLE, WAIT, LOAD_BL, SHIFT_WL, PROG, CLEAR, DONE);
  - the counter-width helper constants.
- Sub-module `bl_wl_loader_piso`: a BL_LEN-bit parallel-load, MSB-first shift register with load and shift enables. The top level holds the FSM and counters.

## Test plan
All scenarios use BL_LEN=4, WL_LEN=2, PROG_CYCLES=2.
- **Single load**: `START`, frames 4'b1010 then 4'b0110.
  - `BL_SIN` sequence is 1,0,1,0 then 0,1,1,0.
  - `WL_SIN` is 1 then 0 on the two SHIFT_WL cycles, then 0 on CLEAR.
  - `PROG_EN` is 2 cycles per frame.
  - `DONE` rises 2 cycles after the last `PROG_EN`.
- **Source stall**: `DIN_VALID` low for 5 cycles in WAIT → `DIN_READY` stays 1 and no shift enables fire. The frame is then accepted on the first valid cycle.
- **Spurious inputs**: `START` during LOAD_BL and `DIN_VALID` during PROG → both ignored; the sequence is identical to the single-load case.
- **Reset mid-LOAD_BL**: `RSTN`=0 for 1 cycle after 2 BL shifts → all outputs 0 on the next cycle, state IDLE. A new `START` restarts with `WL_SIN`=1 on frame 0.
- **Restart from DONE**: `START` in DONE → `DONE` falls and `DIN_READY`=1 on the next cycle.
- **Parity** (`BL_WL_LOADER_PARITY_EN`): frame 4'b1010 with `DIN_PARITY`=1 → `PARITY_ERR`=1 from the cycle after the handshake, and the frame still shifts. `START` clears it.
